uk101_vram_arbiter: RTL and testbench

//  Shares the single-port video RAM between the 6502 bus (CPU) and the character-scanout fetch (VID).

---
 rtl/uk101_vram_arbiter_if.sv | 36 +++
 rtl/uk101_vram_arbiter.sv | 154 +++++++++++++++
 tb/tb_uk101_vram_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uk101_vram_arbiter_if.sv
// Bus bundle between the uk101 VRAM arbiter, its two requesters and the VRAM.
// slave = arbiter side, master = requesters plus RAM (everything around it).
interface uk101_vram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_data;
    logic              vid_overrun;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_valid, vid_data, vid_overrun, cpu_ack, cpu_rdata,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_valid, vid_data, vid_overrun, cpu_ack, cpu_rdata,
               ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/uk101_vram_arbiter.sv
// Shares the single-port synchronous VRAM between character scanout (priority)
// and the 6502 bus, with a starvation escape for the CPU and a one-deep VID pend.
module uk101_vram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk_sys,
    input logic                 reset,
    uk101_vram_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_VID,
        SRC_CPU
    } src_e;

    // Arbitration state
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              inflight;
    logic              armed;
    logic [3:0]        starve;

    // Return pipeline: grant edge -> RAM read edge -> output register edge
    src_e              s1_src;
    src_e              s2_src;

    // Combinational decisions
    logic              vid_cand;
    logic              cpu_cand;
    logic              starve_hit;
    src_e              grant;
    logic [ADDR_W-1:0] vid_sel_addr;
    logic              pend_valid_nx;
    logic [ADDR_W-1:0] pend_addr_nx;
    logic              drop;
    logic [3:0]        starve_nx;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
        vid_cand      = bus.vid_req | pend_valid;
        cpu_cand      = bus.cpu_req & armed & ~inflight;
        starve_hit    = (starve == LIMIT);
        grant         = SRC_NONE;
        vid_sel_addr  = pend_valid ? pend_addr : bus.vid_addr;
        pend_valid_nx = pend_valid;
        pend_addr_nx  = pend_addr;
        drop          = 1'b0;
        starve_nx     = 4'd0;

        if (cpu_cand && (!vid_cand || starve_hit)) begin
            grant = SRC_CPU;
        end else if (vid_cand) begin
            grant = SRC_VID;
        end

        if (grant == SRC_VID) begin
            // The pending address is older; a same-cycle new request takes its place.
            if (pend_valid) begin
                pend_valid_nx = bus.vid_req;
                if (bus.vid_req) begin
                    pend_addr_nx = bus.vid_addr;
                end
            end
        end else if (vid_cand) begin
            if (!pend_valid) begin
                pend_valid_nx = 1'b1;
                pend_addr_nx  = bus.vid_addr;
            end else if (bus.vid_req) begin
                drop = 1'b1;
            end
        end

        if (cpu_cand && grant != SRC_CPU) begin
            starve_nx = starve_hit ? starve : starve + 4'd1;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pend_valid      <= 1'b0;
            pend_addr       <= '0;
            starve          <= 4'd0;
            inflight        <= 1'b0;
            armed           <= 1'b0;
            bus.vid_overrun <= 1'b0;
        end else begin
            pend_valid <= pend_valid_nx;
            pend_addr  <= pend_addr_nx;
            starve     <= starve_nx;
            if (drop) begin
                bus.vid_overrun <= 1'b1;
            end
            if (grant == SRC_CPU) begin
                inflight <= 1'b1;
            end else if (bus.cpu_ack) begin
                inflight <= 1'b0;
            end
            // A held request is re-served only after the requester drops it once.
            if (grant == SRC_CPU) begin
                armed <= 1'b0;
            end else if (!bus.cpu_req) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bus.ram_addr  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
            s1_src        <= SRC_NONE;
            s2_src        <= SRC_NONE;
        end else begin
            bus.ram_we <= (grant == SRC_CPU) && bus.cpu_we;
            if (grant == SRC_CPU) begin
                bus.ram_addr  <= bus.cpu_addr;
                bus.ram_wdata <= bus.cpu_wdata;
            end else if (grant == SRC_VID) begin
                bus.ram_addr <= vid_sel_addr;
            end
            s1_src <= grant;
            s2_src <= s1_src;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bus.vid_valid <= 1'b0;
            bus.vid_data  <= '0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
        end else begin
            bus.vid_valid <= (s2_src == SRC_VID);
            bus.cpu_ack   <= (s2_src == SRC_CPU);
            if (s2_src == SRC_VID) begin
                bus.vid_data <= bus.ram_rdata;
            end
            if (s2_src == SRC_CPU) begin
                bus.cpu_rdata <= bus.ram_rdata;
            end
        end
    end

    a_excl_return: assert property (@(posedge clk_sys) disable iff (reset)
        !(bus.vid_valid && bus.cpu_ack));
    a_starve_bound: assert property (@(posedge clk_sys) disable iff (reset)
        starve <= LIMIT);
endmodule

// File: tb/tb_uk101_vram_arbiter.sv
// Scoreboard bench for uk101_vram_arbiter: a synchronous RAM model, expected
// read data queued at request time and compared when vid_valid / cpu_ack fire.
module tb_uk101_vram_arbiter;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              rd;
        logic [DATA_W-1:0] d;
    } cpu_exp_t;

    logic clk_sys;
    logic reset;
    logic mem_init;

    uk101_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) vif ();

    uk101_vram_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (vif.slave)
    );

    logic [DATA_W-1:0] mem     [2**ADDR_W];
    logic [DATA_W-1:0] exp_mem [2**ADDR_W];
    logic [DATA_W-1:0] vid_q [$];
    cpu_exp_t          cpu_q [$];
    cpu_exp_t          mon_e;
    logic [DATA_W-1:0] mon_v;
    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    int we_cnt   = 0;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        if (a == 11'h123) return 8'h41;
        return a[7:0] ^ {a[10:8], 5'b0} ^ 8'hA5;
    endfunction

    // Synchronous single-port VRAM: read data valid one cycle after the address.
    always @(posedge clk_sys) begin
        if (mem_init) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= pat(ADDR_W'(i));
        end else begin
            if (vif.ram_we) mem[vif.ram_addr] <= vif.ram_wdata;
            vif.ram_rdata <= mem[vif.ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (vif.vid_valid) begin
                if (vid_q.size() == 0) check("vid_unexpected", 32'(1), 32'(0));
                else begin
                    mon_v = vid_q.pop_front();
                    check("vid_data", 32'(vif.vid_data), 32'(mon_v));
                end
            end
            if (vif.cpu_ack) begin
                ack_cnt++;
                if (cpu_q.size() == 0) check("cpu_unexpected", 32'(1), 32'(0));
                else begin
                    mon_e = cpu_q.pop_front();
                    if (mon_e.rd) check("cpu_rdata", 32'(vif.cpu_rdata), 32'(mon_e.d));
                end
            end
            if (vif.ram_we) we_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One uncontended CPU access; hold keeps cpu_req high that many cycles after ack.
    task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, input string tag, input int hold);
        int  we0, ack0, lat;
        bit  done;
        we0  = we_cnt;
        ack0 = ack_cnt;
        cpu_q.push_back('{rd: !we, d: exp_mem[addr]});
        if (we) exp_mem[addr] = wd;
        vif.cpu_req   = 1'b1;
        vif.cpu_we    = we;
        vif.cpu_addr  = addr;
        vif.cpu_wdata = wd;
        lat  = 0;
        done = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (lat == 1) begin
                check({tag, "_ram_addr"}, 32'(vif.ram_addr), 32'(addr));
                check({tag, "_ram_we"}, 32'(vif.ram_we), 32'(we));
                if (we) check({tag, "_ram_wdata"}, 32'(vif.ram_wdata), 32'(wd));
            end
            if (vif.cpu_ack) done = 1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(3));
        repeat (hold) tick();
        vif.cpu_req = 1'b0;
        tick();
        check({tag, "_acks"}, 32'(ack_cnt - ack0), 32'(1));
        check({tag, "_we_cycles"}, 32'(we_cnt - we0), 32'(we));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack;
        int ack0;
        logic [ADDR_W-1:0] a;
        reset         = 1'b1;
        mem_init      = 1'b1;
        vif.vid_req   = 1'b0;
        vif.vid_addr  = '0;
        vif.cpu_req   = 1'b0;
        vif.cpu_we    = 1'b0;
        vif.cpu_addr  = '0;
        vif.cpu_wdata = '0;
        for (int i = 0; i < 2**ADDR_W; i++) exp_mem[i] = pat(ADDR_W'(i));
        repeat (2) @(posedge clk_sys);
        #1;
        mem_init = 1'b0;

        // Reset state
        check("rst_vid_valid", 32'(vif.vid_valid), 32'(0));
        check("rst_cpu_ack", 32'(vif.cpu_ack), 32'(0));
        check("rst_overrun", 32'(vif.vid_overrun), 32'(0));
        check("rst_ram_we", 32'(vif.ram_we), 32'(0));
        check("rst_ram_addr", 32'(vif.ram_addr), 32'(0));
        check("rst_vid_data", 32'(vif.vid_data), 32'(0));
        reset = 1'b0;
        repeat (2) tick();

        // Single VID fetch
        vif.vid_req  = 1'b1;
        vif.vid_addr = 11'h123;
        vid_q.push_back(exp_mem[11'h123]);
        tick();
        vif.vid_req = 1'b0;
        check("vid1_ram_addr", 32'(vif.ram_addr), 32'h123);
        check("vid1_valid_e0", 32'(vif.vid_valid), 32'(0));
        tick();
        check("vid1_valid_e1", 32'(vif.vid_valid), 32'(0));
        tick();
        check("vid1_valid_e2", 32'(vif.vid_valid), 32'(1));
        check("vid1_data_e2", 32'(vif.vid_data), 32'h41);
        tick();
        check("vid1_valid_e3", 32'(vif.vid_valid), 32'(0));
        check("vid1_data_hold", 32'(vif.vid_data), 32'h41);

        // CPU write then read back
        cpu_access(1'b1, 11'h7FF, 8'h5A, "cpu_wr", 0);
        cpu_access(1'b0, 11'h7FF, 8'h00, "cpu_rd", 0);
        check("cpu_rd_value", 32'(vif.cpu_rdata), 32'h5A);

        // Contention then overrun: VID requests every cycle, two CPU reads starve and win
        n_ack        = 0;
        vif.cpu_req  = 1'b1;
        vif.cpu_we   = 1'b0;
        vif.cpu_addr = 11'h200;
        cpu_q.push_back('{rd: 1'b1, d: exp_mem[11'h200]});
        for (int i = 0; i < 20; i++) begin
            a            = 11'h300 + ADDR_W'(i);
            vif.vid_req  = (i <= 12);
            vif.vid_addr = a;
            if (i <= 11) vid_q.push_back(exp_mem[a]);
            if (i == 8) begin
                vif.cpu_req  = 1'b1;
                vif.cpu_addr = 11'h210;
                cpu_q.push_back('{rd: 1'b1, d: exp_mem[11'h210]});
            end
            tick();
            if (i == 3) check("ctn_vid_wins", 32'(vif.ram_addr), 32'h303);
            if (i == 4) check("ctn_cpu_grant", 32'(vif.ram_addr), 32'h200);
            if (i == 5) check("ctn_pend_first", 32'(vif.ram_addr), 32'h304);
            if (i == 11) check("ctn_no_overrun", 32'(vif.vid_overrun), 32'(0));
            if (i == 12) begin
                check("ovr_cpu_grant", 32'(vif.ram_addr), 32'h210);
                check("ovr_flag", 32'(vif.vid_overrun), 32'(1));
            end
            if (i == 13) check("ovr_pend_served", 32'(vif.ram_addr), 32'h30B);
            if (vif.cpu_ack) begin
                check("ctn_ack_edge", 32'(i), (n_ack == 0) ? 32'(6) : 32'(14));
                n_ack++;
                vif.cpu_req = 1'b0;
            end
        end
        check("ctn_ack_count", 32'(n_ack), 32'(2));
        check("ovr_sticky", 32'(vif.vid_overrun), 32'(1));
        check("ctn_vid_drained", 32'(vid_q.size()), 32'(0));

        // Held request after ack: one ack, one RAM write
        cpu_access(1'b1, 11'h155, 8'h33, "held", 10);

        // Reset one cycle into a CPU write
        ack0          = ack_cnt;
        vif.cpu_req   = 1'b1;
        vif.cpu_we    = 1'b1;
        vif.cpu_addr  = 11'h0AA;
        vif.cpu_wdata = 8'h77;
        tick();
        check("rst_mid_we_before", 32'(vif.ram_we), 32'(1));
        reset = 1'b1;
        #1;
        check("rst_mid_we_drop", 32'(vif.ram_we), 32'(0));
        check("rst_mid_overrun_clr", 32'(vif.vid_overrun), 32'(0));
        check("rst_mid_ram_addr", 32'(vif.ram_addr), 32'(0));
        check("rst_mid_cpu_rdata", 32'(vif.cpu_rdata), 32'(0));
        vid_q.delete();
        cpu_q.delete();
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("rst_mid_no_ack", 32'(ack_cnt - ack0), 32'(0));
        vif.cpu_req = 1'b0;
        tick();
        cpu_access(1'b0, 11'h0AA, 8'h00, "rst_aborted_rd", 0);
        cpu_access(1'b1, 11'h0AA, 8'h77, "rst_wr", 0);
        cpu_access(1'b0, 11'h0AA, 8'h00, "rst_rd", 0);
        check("rst_rd_value", 32'(vif.cpu_rdata), 32'h77);

        repeat (6) tick();
        check("end_vid_q_empty", 32'(vid_q.size()), 32'(0));
        check("end_cpu_q_empty", 32'(cpu_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
